fft_frame_buffer: RTL and testbench
===================================

# fft_frame_buffer

Double-buffered (ping-pong) complex sample frame buffer for the 32-point FFT datapath and its successors. It collects N complex fixed-point samples arriving serially over a valid/ready stream, optionally scattering them into bit-reversed order. It presents each completed frame as one parallel bus to the butterfly array and holds it until the consumer acknowledges. Filling of the next frame overlaps with processing of the current one.

## Interface
- I, 19, integer bits per real/imag word
- F, 11, fractional bits per word; W = I+F
- N, 32, frame length; power of two, 2..256
- BITREV, 0, 1 = sample k stored at entry bitrev(k) over log2(N) bits; 0 = natural order
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- IN_VALID  in  1  input sample valid
- IN_READY  out  1  buffer can accept a sample
- IN_r, IN_i  in  W signed  input sample, real/imag
- FLUSH  in  1  discard the partially filled frame
- OUT_VALID  out  1  complete frame presented
- OUT_ACK  in  1  consumer has taken the presented frame
- OUT_r, OUT_i  out  N*W  frame; entry k at [k*W +: W]
- FILL_CNT  out  log2(N)+1  samples held in the current fill bank

## Operation
- Two banks, A and B, each N complex entries. Registers: wr_sel, rd_sel, full[1:0], cnt.
- IN_READY = !full[wr_sel] && !FLUSH.
- Accept when IN_VALID && IN_READY:
  - Write bank[wr_sel][addr], where addr = BITREV ? bitrev(cnt) : cnt.
  - cnt increments.
  - On the Nth accept (cnt == N-1): full[wr_sel] set, wr_sel toggles, cnt returns to 0.
- OUT_VALID = full[rd_sel]. OUT_r/OUT_i always drive bank[rd_sel].
- OUT_ACK with OUT_VALID high clears full[rd_sel] and toggles rd_sel. OUT_ACK with OUT_VALID low is ignored.
- FLUSH: cnt returns to 0 and the entries written so far are stale; they are overwritten by the next frame. Full banks and rd_sel are untouched. FLUSH wins over a same-cycle IN_VALID, so that sample is not accepted.
- Frame completion and OUT_ACK in the same cycle are both honoured. Frame completion sets full[wr_sel]; OUT_ACK clears full[rd_sel], which is the other bank.
- Both banks full: IN_READY low; samples wait upstream and nothing is dropped.
- FILL_CNT = cnt (0..N-1).
- Data is stored bit-exact; there is no arithmetic, rounding or saturation.

## Timing
- Reset values:
  - IN_READY=1, OUT_VALID=0, FILL_CNT=0.
  - All bank entries 0, so OUT_r/OUT_i = 0.
  - wr_sel=rd_sel=0 (bank A).
- RST asserted mid-frame or with full banks: the next cycle shows the reset state. Partial and full frames are lost.
- Latency: OUT_VALID rises the cycle after the Nth sample is accepted.
- IN_READY recovers the cycle after an OUT_ACK that frees a bank.
- Throughput: 1 sample/cycle sustained, provided each frame is acknowledged within N cycles of OUT_VALID rising.
- OUT buses are stable while OUT_VALID is high; they change only on the cycle after OUT_ACK.

## Structure
- Shared package fft_pkg holds:
  - W-derived word width
  - complex sample typedef {re, im}
  - bitrev function (width-parametric)
  - the log2 helper used for FILL_CNT and address width
- One sub-module, fft_buf_bank: N-entry complex register bank with synchronous reset, write enable, write address and a flattened parallel read bus. Instantiate it twice.
- Control logic (cnt, selects, full flags) stays in fft_frame_buffer.

## Test plan
All scenarios use N=32, W=30 unless stated.
- Reset: hold RST 2 cycles → IN_READY=1, OUT_VALID=0, FILL_CNT=0, OUT_r=OUT_i=0.
- Natural order (BITREV=0): stream re=k, im=-k for k=0..31 back-to-back → OUT_VALID=1 on the cycle after the 32nd accept. Entry k: re=k, im=-k. FILL_CNT=0.
- Bit-reversed (BITREV=1): stream re=k → entry0=0, entry1=16, entry3=24, entry31=31.
- Backpressure: stream 70 samples with re=k and no OUT_ACK:
  - IN_READY drops after the 64th accept, and samples 64..69 stall.
  - Pulse OUT_ACK once: the next cycle shows entries 32..63 and IN_READY=1.
  - Remaining samples enter bank A; FILL_CNT counts up from 0.
- FLUSH and overlap:
  - Feed 10 samples, then FLUSH → FILL_CNT=0. Then stream re=100..131 → entries 0..31 = 100..131.
  - Separately, assert OUT_ACK on the same cycle as the last sample of the next frame → OUT_VALID stays 1 and the new frame is shown the following cycle.
- Reset mid-operation: with one bank full and 7 samples in the other, assert RST → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: word width, complex sample type,
// bit-reversal and log2 helpers.
package fft_pkg;

  localparam int unsigned FFT_I = 19;
  localparam int unsigned FFT_F = 11;
  localparam int unsigned FFT_W = FFT_I + FFT_F;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  // Smallest r with 2**r >= n; used for address and fill-count widths.
  function automatic int unsigned fft_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        r = int'(i) + 1;
      end
    end
    return r;
  endfunction

  // Reverse the low 'bits' bits of v (bits <= 8); upper bits come back zero.
  function automatic logic [7:0] bitrev(input logic [7:0] v, input int unsigned bits);
    logic [7:0] r;
    r = 8'd0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(bits)) begin
        r[b] = v[int'(bits) - 1 - b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_buf_bank.sv
// N-entry complex register bank: one write port, every entry visible on a
// flattened parallel read bus (entry k at [k*W +: W]).
module fft_buf_bank #(
  parameter int unsigned N  = 32,
  parameter int unsigned W  = 30,
  parameter int unsigned AW = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WE,
  input  logic [AW-1:0]   WADDR,
  input  logic [W-1:0]    WDATA_R,
  input  logic [W-1:0]    WDATA_I,
  output logic [N*W-1:0]  RD_R,
  output logic [N*W-1:0]  RD_I
);

  logic [N*W-1:0] mem_re_r;
  logic [N*W-1:0] mem_im_r;

  // Entry storage: cleared on reset, one entry written per enabled cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_re_r <= '0;
      mem_im_r <= '0;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (WE && (WADDR == AW'(k))) begin
          mem_re_r[k*W +: W] <= WDATA_R;
          mem_im_r[k*W +: W] <= WDATA_I;
        end
      end
    end
  end

  assign RD_R = mem_re_r;
  assign RD_I = mem_im_r;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong complex frame buffer: serial samples fill one bank while the
// other, once complete, is held on a parallel bus until acknowledged.
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int unsigned I      = FFT_I,
  parameter int unsigned F      = FFT_F,
  parameter int unsigned N      = 32,
  parameter int unsigned BITREV = 0,
  localparam int unsigned W     = I + F,
  localparam int unsigned AW    = fft_log2(N)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic signed [W-1:0]  IN_r,
  input  logic signed [W-1:0]  IN_i,
  input  logic                 FLUSH,
  output logic                 OUT_VALID,
  input  logic                 OUT_ACK,
  output logic [N*W-1:0]       OUT_r,
  output logic [N*W-1:0]       OUT_i,
  output logic [AW:0]          FILL_CNT
);

  localparam logic [AW-1:0] CNT_LAST = AW'(N - 1);

  logic          wr_sel_r, rd_sel_r;
  logic [1:0]    full_r;
  logic [AW-1:0] cnt_r;

  logic          wr_sel_nxt_s, rd_sel_nxt_s;
  logic [1:0]    full_nxt_s;
  logic [AW-1:0] cnt_nxt_s;
  logic          in_ready_s, accept_s, last_s, ack_s;
  logic [7:0]    rev_s;
  logic [AW-1:0] waddr_s;
  logic          we_a_s, we_b_s;
  logic [N*W-1:0] a_re_s, a_im_s, b_re_s, b_im_s;

  // Handshake decode and next-state for counter, selects and full flags.
  // A completing frame targets the write bank, which cannot be full, while an
  // honoured ack targets the full read bank, so both updates can coexist.
  always_comb begin
    in_ready_s   = ~full_r[wr_sel_r] & ~FLUSH;
    accept_s     = IN_VALID & in_ready_s;
    last_s       = accept_s & (cnt_r == CNT_LAST);
    ack_s        = OUT_ACK & full_r[rd_sel_r];
    full_nxt_s   = full_r;
    wr_sel_nxt_s = wr_sel_r;
    rd_sel_nxt_s = rd_sel_r;
    cnt_nxt_s    = cnt_r;
    if (last_s) begin
      full_nxt_s[wr_sel_r] = 1'b1;
      wr_sel_nxt_s         = ~wr_sel_r;
    end else begin
      wr_sel_nxt_s = wr_sel_r;
    end
    if (ack_s) begin
      full_nxt_s[rd_sel_r] = 1'b0;
      rd_sel_nxt_s         = ~rd_sel_r;
    end else begin
      rd_sel_nxt_s = rd_sel_r;
    end
    if (FLUSH || last_s) begin
      cnt_nxt_s = '0;
    end else if (accept_s) begin
      cnt_nxt_s = cnt_r + AW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Write address (natural or bit-reversed) and per-bank write enables.
  always_comb begin
    rev_s = bitrev(8'(cnt_r), AW);
    if (BITREV != 0) begin
      waddr_s = rev_s[AW-1:0];
    end else begin
      waddr_s = cnt_r;
    end
    we_a_s = accept_s & ~wr_sel_r;
    we_b_s = accept_s & wr_sel_r;
  end

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_sel_r <= 1'b0;
      rd_sel_r <= 1'b0;
      full_r   <= 2'b00;
      cnt_r    <= '0;
    end else begin
      wr_sel_r <= wr_sel_nxt_s;
      rd_sel_r <= rd_sel_nxt_s;
      full_r   <= full_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  fft_buf_bank #(.N(N), .W(W), .AW(AW)) u_bank_a (
    .CLK(CLK), .RST(RST), .WE(we_a_s), .WADDR(waddr_s),
    .WDATA_R(IN_r), .WDATA_I(IN_i), .RD_R(a_re_s), .RD_I(a_im_s)
  );

  fft_buf_bank #(.N(N), .W(W), .AW(AW)) u_bank_b (
    .CLK(CLK), .RST(RST), .WE(we_b_s), .WADDR(waddr_s),
    .WDATA_R(IN_r), .WDATA_I(IN_i), .RD_R(b_re_s), .RD_I(b_im_s)
  );

  // Output view: the read bank is always on the bus; flags come from registers.
  always_comb begin
    IN_READY  = in_ready_s;
    OUT_VALID = full_r[rd_sel_r];
    FILL_CNT  = {1'b0, cnt_r};
    if (rd_sel_r) begin
      OUT_r = b_re_s;
      OUT_i = b_im_s;
    end else begin
      OUT_r = a_re_s;
      OUT_i = a_im_s;
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed self-checking bench for fft_frame_buffer (N=32, W=30); a second
// instance with BITREV=1 shares the same stimulus.
module tb_fft_frame_buffer;

  localparam int N = 32;
  localparam int W = 30;

  logic clk, rst, in_valid, flush, out_ack;
  logic signed [W-1:0] in_re, in_im;
  logic in_ready, out_valid, in_ready_br, out_valid_br;
  logic [N*W-1:0] out_re, out_im, out_re_br, out_im_br;
  logic [5:0] fill_cnt, fill_cnt_br;

  int checks = 0;
  int errors = 0;

  fft_frame_buffer #(.I(19), .F(11), .N(N), .BITREV(0)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_r(in_re), .IN_i(in_im), .FLUSH(flush), .OUT_VALID(out_valid),
    .OUT_ACK(out_ack), .OUT_r(out_re), .OUT_i(out_im), .FILL_CNT(fill_cnt)
  );

  fft_frame_buffer #(.I(19), .F(11), .N(N), .BITREV(1)) dut_br (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_br),
    .IN_r(in_re), .IN_i(in_im), .FLUSH(flush), .OUT_VALID(out_valid_br),
    .OUT_ACK(out_ack), .OUT_r(out_re_br), .OUT_i(out_im_br), .FILL_CNT(fill_cnt_br)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hold reset for two cycles; returns just after a falling edge.
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ack = 1'b0;
    in_re = '0; in_im = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic send(input int re, input int im);
    int b;
    b = 0;
    in_valid = 1'b1;
    in_re = W'(re);
    in_im = W'(im);
    #1;
    while (!in_ready && b < 200) begin
      @(negedge clk); #1; b++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: sample %0d not accepted, in_ready=%b required 1", re, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (fill_cnt !== 6'd0) begin errors++; $display("FAIL reset_fill_cnt: got %0d want 0", fill_cnt); end
    checks++; if (out_re !== '0 || out_im !== '0) begin errors++; $display("FAIL reset_out_bus: buses not zero"); end
  endtask

  task automatic test_natural();
    logic [W-1:0] exp_re, exp_im;
    do_reset();
    for (int k = 0; k < N - 1; k++) send(k, -k);
    checks++; if (out_valid !== 1'b0 || fill_cnt !== 6'd31) begin errors++; $display("FAIL nat_before_last: out_valid=%b fill=%0d want 0/31", out_valid, fill_cnt); end
    send(N - 1, -(N - 1));
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nat_out_valid: got %b want 1", out_valid); end
    checks++; if (fill_cnt !== 6'd0) begin errors++; $display("FAIL nat_fill_cnt: got %0d want 0", fill_cnt); end
    for (int k = 0; k < N; k++) begin
      exp_re = W'(k);
      exp_im = W'(-k);
      checks++;
      if (out_re[k*W +: W] !== exp_re || out_im[k*W +: W] !== exp_im) begin
        errors++;
        $display("FAIL nat_entry%0d: got re=%0h im=%0h want re=%0h im=%0h", k, out_re[k*W +: W], out_im[k*W +: W], exp_re, exp_im);
      end
    end
    // Ack releases bank A; bank B is empty so OUT_VALID falls.
    out_ack = 1'b1;
    @(negedge clk); out_ack = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || out_re !== '0) begin errors++; $display("FAIL nat_after_ack: out_valid=%b want 0 with bank B zero", out_valid); end
    // Ack with nothing presented is ignored.
    out_ack = 1'b1;
    @(negedge clk); out_ack = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL nat_idle_ack: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_bitrev();
    do_reset();
    for (int k = 0; k < N; k++) send(k, 0);
    checks++; if (out_valid_br !== 1'b1) begin errors++; $display("FAIL br_out_valid: got %b want 1", out_valid_br); end
    checks++; if (out_re_br[0*W +: W] !== 30'd0) begin errors++; $display("FAIL br_entry0: got %0d want 0", out_re_br[0*W +: W]); end
    checks++; if (out_re_br[1*W +: W] !== 30'd16) begin errors++; $display("FAIL br_entry1: got %0d want 16", out_re_br[1*W +: W]); end
    checks++; if (out_re_br[3*W +: W] !== 30'd24) begin errors++; $display("FAIL br_entry3: got %0d want 24", out_re_br[3*W +: W]); end
    checks++; if (out_re_br[16*W +: W] !== 30'd1) begin errors++; $display("FAIL br_entry16: got %0d want 1", out_re_br[16*W +: W]); end
    checks++; if (out_re_br[31*W +: W] !== 30'd31) begin errors++; $display("FAIL br_entry31: got %0d want 31", out_re_br[31*W +: W]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 64; k++) send(k, 0);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_both_full: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
    checks++; if (out_re[31*W +: W] !== 30'd31) begin errors++; $display("FAIL bp_bank_a: entry31 got %0d want 31", out_re[31*W +: W]); end
    // Sample 64 waits upstream for three cycles.
    in_valid = 1'b1; in_re = 30'd64; in_im = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0 || fill_cnt !== 6'd0) begin errors++; $display("FAIL bp_stall: in_ready=%b fill=%0d want 0/0", in_ready, fill_cnt); end
    out_ack = 1'b1;
    @(negedge clk); out_ack = 1'b0; #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_after_ack: in_ready=%b out_valid=%b want 1/1", in_ready, out_valid); end
    checks++; if (out_re[0*W +: W] !== 30'd32 || out_re[31*W +: W] !== 30'd63) begin errors++; $display("FAIL bp_bank_b: entry0=%0d entry31=%0d want 32/63", out_re[0*W +: W], out_re[31*W +: W]); end
    checks++; if (fill_cnt !== 6'd0) begin errors++; $display("FAIL bp_fill0: got %0d want 0", fill_cnt); end
    send(64, 0);
    checks++; if (fill_cnt !== 6'd1) begin errors++; $display("FAIL bp_fill1: got %0d want 1", fill_cnt); end
    for (int k = 65; k < 70; k++) send(k, 0);
    checks++; if (fill_cnt !== 6'd6) begin errors++; $display("FAIL bp_fill6: got %0d want 6", fill_cnt); end
    checks++; if (out_re[0*W +: W] !== 30'd32) begin errors++; $display("FAIL bp_stable: entry0 got %0d want 32", out_re[0*W +: W]); end
  endtask

  task automatic test_flush_overlap();
    do_reset();
    for (int k = 0; k < 10; k++) send(500 + k, 0);
    // FLUSH with a same-cycle valid sample: the sample is refused.
    flush = 1'b1; in_valid = 1'b1; in_re = 30'd999;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready: got %b want 0", in_ready); end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (fill_cnt !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fl_fill: fill=%0d out_valid=%b want 0/0", fill_cnt, out_valid); end
    for (int k = 0; k < N; k++) send(100 + k, 0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_re[k*W +: W] !== W'(100 + k)) begin errors++; $display("FAIL fl_entry%0d: got %0d want %0d", k, out_re[k*W +: W], 100 + k); end
    end
    // Next frame into bank B; ack bank A on the cycle of its last sample.
    for (int k = 0; k < N - 1; k++) send(200 + k, 0);
    checks++; if (out_valid !== 1'b1 || out_re[0*W +: W] !== 30'd100) begin errors++; $display("FAIL ov_hold: out_valid=%b entry0=%0d want 1/100", out_valid, out_re[0*W +: W]); end
    out_ack = 1'b1;
    send(200 + N - 1, 0);
    out_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL ov_flags: out_valid=%b in_ready=%b want 1/1", out_valid, in_ready); end
    checks++; if (out_re[0*W +: W] !== 30'd200 || out_re[31*W +: W] !== 30'd231) begin errors++; $display("FAIL ov_new_frame: entry0=%0d entry31=%0d want 200/231", out_re[0*W +: W], out_re[31*W +: W]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < N + 7; k++) send(k + 1, -(k + 1));
    checks++; if (fill_cnt !== 6'd7 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre: fill=%0d out_valid=%b want 7/1", fill_cnt, out_valid); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || fill_cnt !== 6'd0) begin errors++; $display("FAIL rm_flags: in_ready=%b out_valid=%b fill=%0d want 1/0/0", in_ready, out_valid, fill_cnt); end
    checks++; if (out_re !== '0 || out_im !== '0) begin errors++; $display("FAIL rm_bus: buses not zero after reset"); end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_backpressure();
    test_flush_overlap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
